// File: rtl/pwm_ctrl_pkg.sv
// Shared state encoding and limits for the PWM breathing sequencer.
package pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UP     = 2'd1,
    DOWN   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int CYC_MIN = 2;

endpackage

// File: rtl/pwm_period_tick.sv
// Period counter and per-step hold counter; both sit at zero while run is low.
module pwm_period_tick #(
  parameter int WIDTH  = 32,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [WIDTH-1:0]  cyc_l,
  input  logic [HOLD_W-1:0] hold_l,
  output logic              tick,
  output logic              step_ev
);

  logic [WIDTH-1:0]  per_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  assign tick    = run && (per_cnt == (cyc_l - WIDTH'(1)));
  assign step_ev = tick && (hold_cnt == hold_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt  <= '0;
      hold_cnt <= '0;
    end else if (!run) begin
      per_cnt  <= '0;
      hold_cnt <= '0;
    end else begin
      per_cnt <= tick ? '0 : per_cnt + WIDTH'(1);
      if (tick) begin
        hold_cnt <= step_ev ? '0 : hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-ramp sequencer driving en/cycle/duty of a pwm instance.
// State | meaning: IDLE wait for start; UP duty rising; DOWN duty falling; FINISH one-cycle done.
module pwm_breath_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HOLD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [WIDTH-1:0]  cfg_cycle,
  input  logic [WIDTH-1:0]  cfg_step,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic              pwm_en,
  output logic [WIDTH-1:0]  pwm_cycle,
  output logic [WIDTH-1:0]  pwm_duty,
  output logic              busy,
  output logic              done
);

  state_t            state, state_n;
  logic [WIDTH-1:0]  cyc_l, step_l, duty_q, duty_n;
  logic [HOLD_W-1:0] hold_l;
  logic              loop_l;
  logic              stop_req, stop_req_n;
  logic              run, tick, step_ev, accept;
  logic [WIDTH:0]    up_sum;

  assign run    = (state == UP) || (state == DOWN);
  assign accept = (state == IDLE) && start && !stop &&
                  (cfg_cycle >= WIDTH'(CYC_MIN)) && (cfg_step != '0);
  assign up_sum = {1'b0, duty_q} + {1'b0, step_l};

  pwm_period_tick #(
    .WIDTH  (WIDTH),
    .HOLD_W (HOLD_W)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .cyc_l   (cyc_l),
    .hold_l  (hold_l),
    .tick    (tick),
    .step_ev (step_ev)
  );

  always_comb begin
    state_n    = state;
    duty_n     = duty_q;
    stop_req_n = stop_req;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n    = UP;
          duty_n     = '0;
          stop_req_n = 1'b0;
        end
      end
      UP, DOWN: begin
        if (stop) stop_req_n = 1'b1;
        // A pending stop is honoured on the very next period boundary, ahead of any step.
        if (tick && (stop_req || stop)) begin
          duty_n  = '0;
          state_n = FINISH;
        end else if (step_ev) begin
          if (state == UP) begin
            if (up_sum >= {1'b0, cyc_l}) begin
              duty_n  = cyc_l;
              state_n = DOWN;
            end else begin
              duty_n = up_sum[WIDTH-1:0];
            end
          end else if (duty_q <= step_l) begin
            duty_n  = '0;
            state_n = loop_l ? UP : FINISH;
          end else begin
            duty_n = duty_q - step_l;
          end
        end
      end
      FINISH: begin
        state_n    = IDLE;
        duty_n     = '0;
        stop_req_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
        duty_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_q   <= '0;
      stop_req <= 1'b0;
      cyc_l    <= '0;
      step_l   <= '0;
      hold_l   <= '0;
      loop_l   <= 1'b0;
    end else begin
      state    <= state_n;
      duty_q   <= duty_n;
      stop_req <= stop_req_n;
      if (accept) begin
        cyc_l  <= cfg_cycle;
        step_l <= cfg_step;
        hold_l <= cfg_hold;
        loop_l <= loop;
      end
    end
  end

  assign busy      = run;
  assign pwm_en    = run;
  assign done      = (state == FINISH);
  assign pwm_duty  = duty_q;
  assign pwm_cycle = cyc_l;

endmodule
